// File: rtl/cvp14_pkg.sv
// Shared opcode, vector-length and FSM encoding definitions for the vector memory sequencer.
package cvp14_pkg;

  localparam int VEC_LEN = 16;

  localparam logic [3:0] FUNC_VLD = 4'b0100;
  localparam logic [3:0] FUNC_VST = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_LOAD_DRAIN = 2'd2,
    ST_STORE      = 2'd3
  } state_e;

  function automatic logic [15:0] sext_off(input logic [5:0] off);
    return {{10{off[5]}}, off};
  endfunction

endpackage

// File: rtl/vmem_seq_if.sv
// Decode, data-memory and VRF signals of the vector memory sequencer.
// Handshake: start is a one-cycle request with no ready; it is taken only while busy is low,
// and done pulses once in the final busy cycle of an accepted operation.
interface vmem_seq_if;
  logic        start;
  logic [3:0]  functype;
  logic [15:0] base;
  logic [5:0]  offset;
  logic [2:0]  vreg;
  logic [15:0] vsrc_data;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [3:0]  elem_idx;
  logic [2:0]  vsrc_reg;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        vrf_we;
  logic [2:0]  vrf_waddr;
  logic [3:0]  vrf_elem;
  logic [15:0] vrf_wdata;

  modport master (
    output start, functype, base, offset, vreg, vsrc_data, mem_rdata,
    input  busy, done, elem_idx, vsrc_reg, mem_addr, mem_re, mem_we, mem_wdata,
           vrf_we, vrf_waddr, vrf_elem, vrf_wdata
  );

  modport slave (
    input  start, functype, base, offset, vreg, vsrc_data, mem_rdata,
    output busy, done, elem_idx, vsrc_reg, mem_addr, mem_re, mem_we, mem_wdata,
           vrf_we, vrf_waddr, vrf_elem, vrf_wdata
  );
endinterface

// File: rtl/vmem_agu.sv
// Element address generator: latches base+sext(offset) and adds the element counter, 16-bit wrap.
module vmem_agu
  import cvp14_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] base,
  input  logic [5:0]  offset,
  output logic [15:0] addr,
  output logic [3:0]  idx
);

  logic [15:0] base_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_off <= '0;
      idx      <= '0;
    end else if (load) begin
      base_off <= base + sext_off(offset);
      idx      <= '0;
    end else if (step) begin
      idx <= idx + 4'd1;
    end
  end

  assign addr = base_off + {12'd0, idx};

endmodule

// File: rtl/vmem_seq.sv
// Vector load/store sequencer: walks VEC_LEN elements between data memory and the VRF.
module vmem_seq
  import cvp14_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  vmem_seq_if.slave   bus,
  output state_e      state_dbg
);

  state_e      state;
  logic        busy_q;
  logic        done_q;
  logic        re_q;
  logic        we_q;
  logic        vrf_we_q;
  logic [3:0]  vrf_elem_q;
  logic [2:0]  vreg_q;
  logic [3:0]  idx;
  logic [15:0] agu_addr;
  logic        op_ok;
  logic        accept;
  logic        last;
  logic        step;

  assign op_ok  = (bus.functype == FUNC_VLD) || (bus.functype == FUNC_VST);
  assign accept = (state == ST_IDLE) && bus.start && op_ok;
  assign last   = (idx == 4'(VEC_LEN - 1));
  assign step   = ((state == ST_LOAD) || (state == ST_STORE)) && !last;

  vmem_agu u_agu (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .base   (bus.base),
    .offset (bus.offset),
    .addr   (agu_addr),
    .idx    (idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      vrf_we_q   <= 1'b0;
      vrf_elem_q <= '0;
      vreg_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q     <= 1'b0;
          vrf_we_q   <= 1'b0;
          vrf_elem_q <= '0;
          if (accept) begin
            vreg_q <= bus.vreg;
            busy_q <= 1'b1;
            if (bus.functype == FUNC_VLD) begin
              state <= ST_LOAD;
              re_q  <= 1'b1;
            end else begin
              state <= ST_STORE;
              we_q  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // Read data for the element addressed now arrives next cycle.
          vrf_we_q   <= 1'b1;
          vrf_elem_q <= idx;
          if (last) begin
            state  <= ST_LOAD_DRAIN;
            re_q   <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_LOAD_DRAIN: begin
          state      <= ST_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          vrf_we_q   <= 1'b0;
          vrf_elem_q <= '0;
        end
        ST_STORE: begin
          if (idx == 4'(VEC_LEN - 2)) done_q <= 1'b1;
          if (last) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_dbg     = state;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = (re_q || we_q) ? agu_addr : '0;
  assign bus.elem_idx  = we_q ? idx : '0;
  assign bus.vsrc_reg  = we_q ? vreg_q : '0;
  assign bus.mem_wdata = we_q ? bus.vsrc_data : '0;
  assign bus.vrf_we    = vrf_we_q;
  assign bus.vrf_waddr = vrf_we_q ? vreg_q : '0;
  assign bus.vrf_elem  = vrf_we_q ? vrf_elem_q : '0;
  assign bus.vrf_wdata = vrf_we_q ? bus.mem_rdata : '0;

endmodule

// File: doc/vmem_seq.md
VMEM_SEQ -- requirements
Module: vmem_seq

Interface
REQ-001 VEC_LEN, 16, element count per vector; fixed, not a port parameter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle issue pulse from decode for VLD/VST.
REQ-005 functype  in  4  decoded opcode: 4'b0100 VLD, 4'b0101 VST; other values ignored.
REQ-006 base  in  16  scalar base register contents (addr1 read data).
REQ-007 offset  in  6  two's-complement element offset.
REQ-008 vreg  in  3  VLD destination register, or VST source register.
REQ-009 vsrc_data  in  16  VRF read data for (vreg, elem_idx); combinational read.
REQ-010 mem_rdata  in  16  data memory read data, valid one cycle after mem_re.
REQ-011 busy  out  1  sequencer active; fetch stalls while high.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 elem_idx  out  4  VRF element read index during VST.
REQ-014 vsrc_reg  out  3  VRF read register during VST.
REQ-015 mem_addr  out  16  data memory address.
REQ-016 mem_re / mem_we  out  1 each  memory read/write strobes; never both high.
REQ-017 mem_wdata  out  16  store data.
REQ-018 vrf_we  out  1  VRF element write enable.
REQ-019 vrf_waddr / vrf_elem / vrf_wdata  out  3/4/16  VRF write register, element, data.

Function
REQ-020 FSM states: IDLE, LOAD, LOAD_DRAIN, STORE; busy SHALL be high in every state except IDLE.
REQ-021 In IDLE, start with functype VLD/VST SHALL latch base+sext(offset), vreg, and zero element counter; next state LOAD or STORE.
REQ-022 start with any other functype, or start while busy, SHALL be ignored with no state change.
REQ-023 Element address SHALL be (base + sext(offset) + k) mod 2^16 for element k, 0..15; wrap-around silent.
REQ-024 LOAD: cycles 1..16 after start SHALL assert mem_re with element k address in cycle k+1.
REQ-025 Read data for element k SHALL be written to VRF at (vreg, k) in cycle k+2, vrf_wdata = mem_rdata unregistered.
REQ-026 After element 15 read, FSM SHALL enter LOAD_DRAIN for one cycle (cycle 17), perform final write, assert done, return to IDLE.
REQ-027 VLD total: busy high cycles 1..17; 16 reads, 16 VRF writes.
REQ-028 STORE: cycles 1..16 SHALL drive elem_idx=k, vsrc_reg=vreg, mem_we=1, mem_addr element k, mem_wdata=vsrc_data.
REQ-029 STORE SHALL assert done in cycle 16 and return to IDLE next edge; busy high cycles 1..16.
REQ-030 Outputs not named active in current state SHALL be zero (strobes, done, addresses, data).
REQ-031 New start accepted in the cycle after done (back-to-back issue).

Reset
REQ-032 rst SHALL force IDLE immediately; busy, done, mem_re, mem_we, vrf_we, all addresses, indices, data outputs = 0.
REQ-033 Reset mid-operation SHALL abandon the access; no further memory or VRF writes, no done pulse.
REQ-034 Internal counter and latched operands SHALL reset to 0.

Structure
REQ-035 Opcode localparams (VLD, VST), VEC_LEN, and FSM state encoding SHALL live in shared package cvp14_pkg.
REQ-036 Address generation (latched base+offset plus counter, 16-bit wrap) SHALL be sub-module vmem_agu.
REQ-037 No memory or VRF storage inside vmem_seq.

Verification
REQ-038 VLD base=0x0100, offset=6'h02: mem_re addresses 0x0102..0x0111 cycles 1..16; vrf_we elems 0..15 cycles 2..17; done cycle 17.
REQ-039 VST vreg=3, base=0x2000, offset=6'h3F (-1): mem_we addresses 0x1FFF..0x200E cycles 1..16, wdata tracks vsrc_data per elem_idx; done cycle 16.
REQ-040 VLD base=0xFFF8, offset=0: addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
REQ-041 Second start at cycle 5 of VLD: ignored; exactly 16 reads, one done.
REQ-042 rst asserted at cycle 8 of VST: all outputs zero same cycle; no further mem_we; no done; busy low.
REQ-043 VST start in cycle after VLD done: accepted; mem_we begins next cycle; mem_re/mem_we never overlap.
